writeback_queue: RTL and testbench
==================================

# writeback_queue

Buffers register-file writeback requests from the ALU and memory (load) paths and drains them, one per cycle, into the 8×16 register file's single write port. Decouples producers from write-port contention and presents a forwarding lookup so decode can read values still in flight. Sits between the execute/memory stages and the register file write port (`write_enable`/`write_addr`/`write_data`).

## Interface
- `DATA_W`, 16, width of a register value
- `ADDR_W`, 3, register index width (8 registers)
- `DEPTH`, 4, queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `mem_valid`  in  1  load result available
- `mem_ready`  out  1  queue accepts mem request
- `mem_addr`  in  ADDR_W  destination register
- `mem_data`  in  DATA_W  value
- `alu_valid`  in  1  ALU result available
- `alu_ready`  out  1  queue accepts ALU request
- `alu_addr`  in  ADDR_W  destination register
- `alu_data`  in  DATA_W  value
- `rf_stall`  in  1  register-file write port unavailable this cycle
- `rf_write_enable`  out  1  drive register-file `write_enable`
- `rf_write_addr`  out  ADDR_W  drive `write_addr`
- `rf_write_data`  out  DATA_W  drive `write_data`
- `fwd_addr`  in  ADDR_W  forwarding lookup index
- `fwd_hit`  out  1  a queued entry targets `fwd_addr`
- `fwd_data`  out  DATA_W  youngest queued value for `fwd_addr`, 0 when no hit
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `full`, `empty`  out  1  occupancy == DEPTH / == 0

## Operation
- Circular FIFO: `head` and `tail` pointers (each $clog2(DEPTH) bits, wrap modulo DEPTH) plus `count` register.
- Push: at most one per cycle. Mem has fixed priority.
  - `mem_ready = !full`; `alu_ready = !full && !mem_valid`.
  - Push on `mem_valid && mem_ready`, else on `alu_valid && alu_ready`; entry written at `tail`, `tail` increments.
  - Producers hold valid/addr/data until ready; the block never drops an accepted request.
- Drain: `rf_write_enable = !empty && !rf_stall`; `rf_write_addr`/`rf_write_data` = head entry (combinational). On an edge with `rf_write_enable` = 1, `head` increments (pop).
- Simultaneous push and pop: `count` unchanged, both pointers advance. Push while full is blocked by ready; a pop in the same cycle does not re-open ready (no push-through).
- Order: entries retire strictly in acceptance order, so writes to the same register land oldest first.
- Forwarding: compare `fwd_addr` against every occupied entry; `fwd_hit` if any match; `fwd_data` = youngest matching entry (closest to `tail`). Purely combinational, includes the head entry being written this cycle.
- Register 0 receives no special handling; writes to it are queued and issued like any other.
- Reset (`reset_n` low, any time): `head`=`tail`=`count`=0, all queued entries discarded, entry storage need not be cleared. Outputs during and after reset: `rf_write_enable`=0, `empty`=1, `full`=0, `count`=0, `fwd_hit`=0, `fwd_data`=0, `mem_ready`=1, `alu_ready`=`!mem_valid`.

## Timing
- Acceptance to `rf_write_enable`: 1 cycle minimum (entry visible at head the cycle after the push edge); the register file captures it on the following edge.
- Throughput: 1 push and 1 pop per cycle sustained while `rf_stall` = 0.
- `rf_stall` acts in the same cycle: it gates `rf_write_enable` combinationally, with no added latency.
- `fwd_hit`/`fwd_data` reflect state after the most recent edge. A request accepted this cycle is not forwarded until the next cycle.
- `mem_ready`/`alu_ready` depend combinationally on `full` and `mem_valid` only, with no path from `rf_stall`.
- Reset is asynchronous assert. Deassertion is sampled synchronously (no state change until the first rising edge with `reset_n` high).

## Test plan
- Reset then single ALU push (addr 3, data 0x1234): `alu_ready`=1; next cycle `rf_write_enable`=1, addr 3, data 0x1234. Following cycle `empty`=1.
- Both valid same cycle (mem r1=0xAAAA, alu r2=0x5555): mem accepted first, `alu_ready`=0; r1 issued before r2, one cycle apart.
- Hold `rf_stall`=1, push 4 entries: `full`=1, `count`=4, both readies 0. Release stall: 4 writes in order on 4 consecutive cycles; ready returns the cycle after the first pop.
- Queue r5=0x0001 then r5=0x0002 under stall: `fwd_addr`=5 gives `fwd_hit`=1, `fwd_data`=0x0002; `fwd_addr`=6 gives `fwd_hit`=0, `fwd_data`=0.
- Continuous push+pop for 10 cycles across pointer wrap: `count` constant at 1, data order preserved, no lost or duplicated writes.
- Assert `reset_n`=0 mid-cycle with 3 entries queued: outputs reset immediately without a clock edge. After release, `empty`=1 and no write is issued.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: buffers ALU and load results in a small circular FIFO and
// drains them in order, one per cycle, into the register file write port.
module writeback_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [ADDR_W-1:0]          mem_addr,
   input  logic [DATA_W-1:0]          mem_data,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [ADDR_W-1:0]          alu_addr,
   input  logic [DATA_W-1:0]          alu_data,
   input  logic                       rf_stall,
   output logic                       rf_write_enable,
   output logic [ADDR_W-1:0]          rf_write_addr,
   output logic [DATA_W-1:0]          rf_write_data,
   input  logic [ADDR_W-1:0]          fwd_addr,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   logic              w_full;
   logic              w_empty;
   logic              w_mem_ready;
   logic              w_alu_ready;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_push_addr;
   logic [DATA_W-1:0] w_push_data;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;

   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_empty     = (r_count == {CNT_W{1'b0}});
   // Ready depends only on occupancy and mem_valid; a same-cycle pop never re-opens it.
   assign w_mem_ready = !w_full;
   assign w_alu_ready = !w_full && !mem_valid;
   assign w_pop       = !w_empty && !rf_stall;

   // Push arbitration: the load path has fixed priority over the ALU path.
   always_comb begin
      w_push      = 1'b0;
      w_push_addr = alu_addr;
      w_push_data = alu_data;
      if (mem_valid && w_mem_ready) begin
         w_push      = 1'b1;
         w_push_addr = mem_addr;
         w_push_data = mem_data;
      end else if (alu_valid && w_alu_ready) begin
         w_push      = 1'b1;
         w_push_addr = alu_addr;
         w_push_data = alu_data;
      end else begin
         w_push      = 1'b0;
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_tail <= r_tail + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_head <= r_head + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; stale slots are never observed because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= w_push_addr;
         r_data[r_tail] <= w_push_data;
      end
   end

   // Forwarding scan from oldest to youngest so the youngest match wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = {DATA_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == fwd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[r_head + PTR_W'(k)];
         end else begin
            w_fwd_hit  = w_fwd_hit;
            w_fwd_data = w_fwd_data;
         end
      end
   end

   assign mem_ready       = w_mem_ready;
   assign alu_ready       = w_alu_ready;
   assign rf_write_enable = w_pop;
   assign rf_write_addr   = r_addr[r_head];
   assign rf_write_data   = r_data[r_head];
   assign fwd_hit         = w_fwd_hit;
   assign fwd_data        = w_fwd_data;
   assign count           = r_count;
   assign full            = w_full;
   assign empty           = w_empty;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed testbench for writeback_queue: scoreboard of expected register-file
// writes checked by an independent monitor, plus direct status/forwarding checks.
module tb_writeback_queue;

   logic        clk;
   logic        reset_n;
   logic        mem_valid;
   logic        mem_ready;
   logic [2:0]  mem_addr;
   logic [15:0] mem_data;
   logic        alu_valid;
   logic        alu_ready;
   logic [2:0]  alu_addr;
   logic [15:0] alu_data;
   logic        rf_stall;
   logic        rf_write_enable;
   logic [2:0]  rf_write_addr;
   logic [15:0] rf_write_data;
   logic [2:0]  fwd_addr;
   logic        fwd_hit;
   logic [15:0] fwd_data;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_checks = 0;
   int  n_errors = 0;

   writeback_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .rf_stall(rf_stall), .rf_write_enable(rf_write_enable),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_req(input logic [2:0] a, input logic [15:0] d);
      alu_valid = 1'b1;
      alu_addr  = a;
      alu_data  = d;
   endtask

   // Monitor: every issued write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rf_write_enable === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL wr_unexpected: got r%0d=%h expected no write at %0t",
                     rf_write_addr, rf_write_data, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (rf_write_addr !== mon_e.a || rf_write_data !== mon_e.d) begin
               n_errors++;
               $display("FAIL wr_order: got r%0d=%h expected r%0d=%h at %0t",
                        rf_write_addr, rf_write_data, mon_e.a, mon_e.d, $time);
            end
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      mem_valid = 1'b0; mem_addr = 3'd0; mem_data = 16'h0000;
      alu_valid = 1'b0; alu_addr = 3'd0; alu_data = 16'h0000;
      rf_stall  = 1'b0; fwd_addr = 3'd0;
      step();
      step();
      chk("rst_we",    {31'd0, rf_write_enable}, 32'd0);
      chk("rst_empty", {31'd0, empty},           32'd1);
      chk("rst_full",  {31'd0, full},            32'd0);
      chk("rst_count", {29'd0, count},           32'd0);
      chk("rst_fhit",  {31'd0, fwd_hit},         32'd0);
      chk("rst_fdata", {16'd0, fwd_data},        32'd0);
      chk("rst_mrdy",  {31'd0, mem_ready},       32'd1);
      chk("rst_ardy",  {31'd0, alu_ready},       32'd1);
      reset_n = 1'b1;

      // Single ALU push, issued the next cycle.
      alu_req(3'd3, 16'h1234); exp_q.push_back({3'd3, 16'h1234});
      @(negedge clk);
      chk("t1_ardy", {31'd0, alu_ready}, 32'd1);
      chk("t1_we0",  {31'd0, rf_write_enable}, 32'd0);
      step(); alu_valid = 1'b0;
      @(negedge clk);
      chk("t1_we1",   {31'd0, rf_write_enable}, 32'd1);
      chk("t1_count", {29'd0, count}, 32'd1);
      step();
      @(negedge clk);
      chk("t1_empty", {31'd0, empty}, 32'd1);
      step();

      // Mem and ALU together: mem wins, ALU follows one cycle later.
      mem_valid = 1'b1; mem_addr = 3'd1; mem_data = 16'hAAAA;
      alu_req(3'd2, 16'h5555);
      exp_q.push_back({3'd1, 16'hAAAA});
      exp_q.push_back({3'd2, 16'h5555});
      @(negedge clk);
      chk("t2_mrdy", {31'd0, mem_ready}, 32'd1);
      chk("t2_ardy", {31'd0, alu_ready}, 32'd0);
      step(); mem_valid = 1'b0;
      @(negedge clk);
      chk("t2_ardy2", {31'd0, alu_ready}, 32'd1);
      chk("t2_addr1", {29'd0, rf_write_addr}, 32'd1);
      step(); alu_valid = 1'b0;
      @(negedge clk);
      chk("t2_we2",   {31'd0, rf_write_enable}, 32'd1);
      chk("t2_addr2", {29'd0, rf_write_addr}, 32'd2);
      step();
      @(negedge clk);
      chk("t2_empty", {31'd0, empty}, 32'd1);
      step();

      // Fill under stall, then drain; register 0 is queued like any other.
      rf_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_req(3'(4 + i), 16'h0A04 + 16'(i));
         exp_q.push_back({3'(4 + i), 16'h0A04 + 16'(i)});
         @(negedge clk);
         chk("t3_stall_we", {31'd0, rf_write_enable}, 32'd0);
         step();
      end
      alu_req(3'd0, 16'h0B00);
      @(negedge clk);
      chk("t3_full",  {31'd0, full}, 32'd1);
      chk("t3_count", {29'd0, count}, 32'd4);
      chk("t3_mrdy",  {31'd0, mem_ready}, 32'd0);
      chk("t3_ardy",  {31'd0, alu_ready}, 32'd0);
      step();
      rf_stall = 1'b0;
      exp_q.push_back({3'd0, 16'h0B00});
      @(negedge clk);
      chk("t3_we_a",      {31'd0, rf_write_enable}, 32'd1);
      chk("t3_no_pthru",  {31'd0, alu_ready}, 32'd0);
      step();
      @(negedge clk);
      chk("t3_we_b",   {31'd0, rf_write_enable}, 32'd1);
      chk("t3_ardy_b", {31'd0, alu_ready}, 32'd1);
      step(); alu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_we_c", {31'd0, rf_write_enable}, 32'd1);
         step();
      end
      @(negedge clk);
      chk("t3_empty", {31'd0, empty}, 32'd1);
      step();

      // Forwarding of the youngest entry for a repeated destination.
      rf_stall = 1'b1; fwd_addr = 3'd5;
      alu_req(3'd5, 16'h0001); exp_q.push_back({3'd5, 16'h0001});
      @(negedge clk);
      chk("t4_nofwd_new", {31'd0, fwd_hit}, 32'd0);
      step();
      alu_req(3'd5, 16'h0002); exp_q.push_back({3'd5, 16'h0002});
      @(negedge clk);
      chk("t4_hit_old",  {31'd0, fwd_hit}, 32'd1);
      chk("t4_data_old", {16'd0, fwd_data}, 32'h0001);
      step(); alu_valid = 1'b0;
      @(negedge clk);
      chk("t4_hit",  {31'd0, fwd_hit}, 32'd1);
      chk("t4_data", {16'd0, fwd_data}, 32'h0002);
      fwd_addr = 3'd6;
      #1;
      chk("t4_miss",      {31'd0, fwd_hit}, 32'd0);
      chk("t4_miss_data", {16'd0, fwd_data}, 32'h0000);
      step(); rf_stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t4_drain_we", {31'd0, rf_write_enable}, 32'd1);
         step();
      end
      @(negedge clk);
      chk("t4_empty", {31'd0, empty}, 32'd1);
      step();

      // Sustained push+pop across pointer wrap.
      for (int i = 0; i <= 10; i++) begin
         alu_req(3'(i), 16'hC000 + 16'(i));
         exp_q.push_back({3'(i), 16'hC000 + 16'(i)});
         @(negedge clk);
         if (i > 0) begin
            chk("t5_count", {29'd0, count}, 32'd1);
            chk("t5_we",    {31'd0, rf_write_enable}, 32'd1);
         end
         step();
      end
      alu_valid = 1'b0;
      @(negedge clk);
      chk("t5_last_we", {31'd0, rf_write_enable}, 32'd1);
      step();
      @(negedge clk);
      chk("t5_empty", {31'd0, empty}, 32'd1);
      step();

      // Asynchronous reset with three entries queued.
      rf_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_req(3'(1 + i), 16'hD000 + 16'(i));
         @(negedge clk);
         step();
      end
      alu_valid = 1'b0; fwd_addr = 3'd2;
      @(negedge clk);
      chk("t6_count3", {29'd0, count}, 32'd3);
      chk("t6_fdata",  {16'd0, fwd_data}, 32'hD001);
      step();
      rf_stall = 1'b0;
      #1;
      chk("t6_we_pre", {31'd0, rf_write_enable}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_we",    {31'd0, rf_write_enable}, 32'd0);
      chk("t6_empty", {31'd0, empty}, 32'd1);
      chk("t6_count", {29'd0, count}, 32'd0);
      chk("t6_full",  {31'd0, full}, 32'd0);
      chk("t6_fhit",  {31'd0, fwd_hit}, 32'd0);
      chk("t6_fdat0", {16'd0, fwd_data}, 32'd0);
      chk("t6_mrdy",  {31'd0, mem_ready}, 32'd1);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_post_we",    {31'd0, rf_write_enable}, 32'd0);
         chk("t6_post_empty", {31'd0, empty}, 32'd1);
         step();
      end

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
